// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-hot-low column drive, synchronized and debounced rows,
// hex key code and a two-digit history for the seven-segment display path.
`timescale 1ns/1ps
module keypad_scanner #(
    parameter int SCAN_DIV     = 4096,
    parameter int DEBOUNCE_CNT = 65536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       key_valid,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} state_t;

    state_t        state;
    logic [3:0]    sync1, rs;
    logic [1:0]    col, lrow, low_row;
    logic [DW-1:0] dwell;
    logic [CW-1:0] dbc;
    logic          row_hi;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Lowest-index closed row wins when several rows in the column are low.
    always_comb begin
        if (!rs[0])      low_row = 2'd0;
        else if (!rs[1]) low_row = 2'd1;
        else if (!rs[2]) low_row = 2'd2;
        else             low_row = 2'd3;
    end

    assign row_hi = rs[lrow];
    assign cols   = ~(4'b0001 << col);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= 4'hF;
            rs        <= 4'hF;
            state     <= SCAN;
            col       <= 2'd0;
            lrow      <= 2'd0;
            dwell     <= '0;
            dbc       <= '0;
            key_valid <= 1'b0;
            digit_new <= 4'h0;
            digit_old <= 4'h0;
        end else begin
            sync1     <= rows;
            rs        <= sync1;
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (rs != 4'hF) begin
                            lrow  <= low_row;
                            dbc   <= '0;
                            state <= PRESS_DB;
                        end else begin
                            col <= col + 2'd1;
                        end
                    end else begin
                        dwell <= dwell + DW'(1);
                    end
                end
                PRESS_DB: begin
                    if (row_hi) begin
                        dbc   <= '0;
                        col   <= col + 2'd1;
                        state <= SCAN;
                    end else if (dbc == DB_LAST) begin
                        key_valid <= 1'b1;
                        digit_old <= digit_new;
                        digit_new <= key_code(lrow, col);
                        dbc       <= '0;
                        state     <= HELD;
                    end else begin
                        dbc <= dbc + CW'(1);
                    end
                end
                HELD: begin
                    // Other rows are ignored here: no rollover, no second key.
                    if (row_hi) begin
                        dbc   <= '0;
                        state <= RELEASE_DB;
                    end
                end
                RELEASE_DB: begin
                    if (!row_hi) begin
                        dbc   <= '0;
                        state <= HELD;
                    end else if (dbc == DB_LAST) begin
                        dbc   <= '0;
                        dwell <= '0;
                        col   <= col + 2'd1;
                        state <= SCAN;
                    end else begin
                        dbc <= dbc + CW'(1);
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: scenario tasks plus randomized presses scored
// against a key-legend table and a two-deep digit history.
`timescale 1ns/1ps
module tb_keypad_scanner;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       key_valid;
    logic [3:0] digit_new, digit_old;

    logic [15:0] pressed = '0;  // bit r*4+c: key at row r, column c is closed
    int passed = 0, total = 0;
    int pulses = 0, onehot_bad = 0, digit_bad = 0;
    logic [3:0] prev_new = 4'h0, prev_old = 4'h0;
    logic [3:0] exp_new = 4'h0, exp_old = 4'h0;

    // Legend order: rows 0..3, columns 0..3.
    int legend [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
        .clk(clk), .reset(reset), .rows(rows), .cols(cols),
        .key_valid(key_valid), .digit_new(digit_new), .digit_old(digit_old)
    );

    always #5 clk = ~clk;

    // Passive keypad: a closed key pulls its row low while its column is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid) pulses++;
        if ($countones(~cols) != 1) onehot_bad++;
        if (reset && !key_valid && (digit_new != prev_new || digit_old != prev_old)) digit_bad++;
        prev_new = digit_new;
        prev_old = digit_old;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic accept(input int idx);
        exp_old = exp_new;
        exp_new = legend[idx][3:0];
    endtask

    task automatic test_reset;
        logic [3:0] e;
        reset = 1'b0;
        cyc(5);
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (cols !== 4'b1110) $display("FAIL reset_cols got %b want 1110", cols); else passed++;
        total++; if (key_valid !== 1'b0) $display("FAIL reset_kv got %b want 0", key_valid); else passed++;
        total++; if ({digit_new, digit_old} !== 8'h00) $display("FAIL reset_digits got %h%h want 00", digit_new, digit_old); else passed++;
        for (int k = 1; k < 16; k++) begin
            @(posedge clk); #1;
            e = 4'b0001 << ((k / 4) % 4);
            e = ~e;
            total++; if (cols !== e) $display("FAIL scan_cols k=%0d got %b want %b", k, cols, e); else passed++;
        end
    endtask

    task automatic test_single_press;
        int p0 = pulses;
        pressed[5] = 1'b1;
        cyc(100);
        total++; if (cols !== 4'b1101) $display("FAIL held_cols got %b want 1101", cols); else passed++;
        pressed = '0;
        cyc(30);
        accept(5);
        total++; if (pulses - p0 != 1) $display("FAIL press5_pulses got %0d want 1", pulses - p0); else passed++;
        total++; if (digit_new !== exp_new || digit_old !== exp_old)
            $display("FAIL press5_digits got %h/%h want %h/%h", digit_new, digit_old, exp_new, exp_old); else passed++;
    endtask

    task automatic test_bounce;
        int p0 = pulses;
        bit found = 0;
        for (int i = 0; i < 20 && cols == 4'b1011; i++) cyc(1);
        for (int i = 0; i < 20 && cols != 4'b1011; i++) cyc(1);
        pressed[10] = 1'b1;
        cyc(5);
        total++; if (cols !== 4'b1011) $display("FAIL bounce_hold_cols got %b want 1011", cols); else passed++;
        pressed = '0;
        for (int i = 0; i < 8 && !found; i++) begin
            cyc(1);
            if (cols == 4'b0111) found = 1;
        end
        total++; if (!found) $display("FAIL bounce_resume got %b want 0111", cols); else passed++;
        cyc(20);
        total++; if (pulses != p0) $display("FAIL bounce_pulses got %0d want 0", pulses - p0); else passed++;
        total++; if (digit_new !== exp_new || digit_old !== exp_old)
            $display("FAIL bounce_digits got %h/%h want %h/%h", digit_new, digit_old, exp_new, exp_old); else passed++;
    endtask

    task automatic test_back_to_back;
        int p0 = pulses;
        pressed[2] = 1'b1; cyc(60); pressed = '0; accept(2);
        cyc(20);
        pressed[3] = 1'b1; cyc(60); pressed = '0; accept(3);
        cyc(30);
        total++; if (pulses - p0 != 2) $display("FAIL b2b_pulses got %0d want 2", pulses - p0); else passed++;
        total++; if (digit_new !== exp_new || digit_old !== exp_old)
            $display("FAIL b2b_digits got %h/%h want %h/%h", digit_new, digit_old, exp_new, exp_old); else passed++;
    endtask

    task automatic test_rollover;
        int p0 = pulses;
        pressed[0] = 1'b1; cyc(40); accept(0);
        pressed[8] = 1'b1; pressed[1] = 1'b1; cyc(40);
        pressed = '0;
        cyc(30);
        total++; if (pulses - p0 != 1) $display("FAIL rollover_pulses got %0d want 1", pulses - p0); else passed++;
        total++; if (digit_new !== exp_new || digit_old !== exp_old)
            $display("FAIL rollover_digits got %h/%h want %h/%h", digit_new, digit_old, exp_new, exp_old); else passed++;
    endtask

    task automatic test_random;
        for (int n = 0; n < 8; n++) begin
            int idx = $urandom_range(15, 0);
            int p0 = pulses;
            pressed[idx] = 1'b1;
            cyc(40 + $urandom_range(40, 0));
            pressed = '0;
            accept(idx);
            cyc(40);
            total++; if (pulses - p0 != 1) $display("FAIL rand%0d_pulses key %0d got %0d want 1", n, idx, pulses - p0); else passed++;
            total++; if (digit_new !== exp_new || digit_old !== exp_old)
                $display("FAIL rand%0d_digits key %0d got %h/%h want %h/%h", n, idx, digit_new, digit_old, exp_new, exp_old); else passed++;
        end
    endtask

    task automatic test_reset_held;
        int p0 = pulses;
        pressed[13] = 1'b1;
        cyc(40);
        accept(13);
        total++; if (pulses - p0 != 1) $display("FAIL key0_pulses got %0d want 1", pulses - p0); else passed++;
        #2 reset = 1'b0;
        #1;
        exp_new = 4'h0; exp_old = 4'h0;
        total++; if (cols !== 4'b1110) $display("FAIL midreset_cols got %b want 1110", cols); else passed++;
        total++; if (key_valid !== 1'b0 || digit_new !== 4'h0 || digit_old !== 4'h0)
            $display("FAIL midreset_outs got kv=%b %h/%h want 0 0/0", key_valid, digit_new, digit_old); else passed++;
        cyc(5);
        reset = 1'b1;
        p0 = pulses;
        cyc(40);
        accept(13);
        total++; if (pulses - p0 != 1) $display("FAIL repress_pulses got %0d want 1", pulses - p0); else passed++;
        total++; if (digit_new !== exp_new || digit_old !== exp_old)
            $display("FAIL repress_digits got %h/%h want %h/%h", digit_new, digit_old, exp_new, exp_old); else passed++;
        pressed = '0;
        cyc(30);
    endtask

    initial begin
        test_reset;
        test_single_press;
        test_bounce;
        test_back_to_back;
        test_rollover;
        test_random;
        test_reset_held;
        total++; if (onehot_bad != 0) $display("FAIL cols_onehot got %0d bad cycles want 0", onehot_bad); else passed++;
        total++; if (digit_bad != 0) $display("FAIL digit_hold got %0d bad changes want 0", digit_bad); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
